// File: rtl/holy_axi_arbiter.sv
// N-requester arbiter for a single shared AXI master port: round-robin or fixed priority,
// outstanding-transaction tracking with drain-before-regrant, cap blocking and forced rotation.
module holy_axi_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned PRIORITY_MODE   = 0,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned HOLD_MAX        = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_valid,
    output logic                       addr_block,
    input  logic                       arvalid,
    input  logic                       arready,
    input  logic                       awvalid,
    input  logic                       awready,
    input  logic                       rvalid,
    input  logic                       rready,
    input  logic                       rlast,
    input  logic                       bvalid,
    input  logic                       bready,
    output logic                       idle,
    output logic                       err
);

    localparam int unsigned IW  = $clog2(NUM_REQ);
    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1) + 1;
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned HW  = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam int unsigned HW1 = HW + 1;

    localparam logic [CW-1:0] OUT_LIM  = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   OUT_SAT  = {1'b0, {CW{1'b1}}};
    localparam logic [HW:0]   HOLD_LIM = HW1'(HOLD_MAX);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANTED,
        S_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        grant_idx_q, grant_idx_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]        outstanding_q, outstanding_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
    logic                 err_q, err_d;

    logic                 ar_hs, aw_hs, r_done, b_done;
    logic [1:0]           inc, dec;
    logic [CW-1:0]        dec_ext, dec_eff;
    logic [CW:0]          cnt_sum;
    logic [HW:0]          hold_sum;
    logic                 win_found, release_req, go_idle;
    logic [IW-1:0]        win_idx;
    int unsigned          base, cand;

    assign ar_hs  = arvalid & arready;
    assign aw_hs  = awvalid & awready;
    assign r_done = rvalid & rready & rlast;
    assign b_done = bvalid & bready;
    assign inc    = (state_q == S_IDLE) ? 2'd0 : ({1'b0, ar_hs} + {1'b0, aw_hs});
    assign dec    = {1'b0, r_done} + {1'b0, b_done};

    // A response with nothing outstanding is flagged and not allowed to underflow the count.
    always_comb begin
        dec_ext       = CW'(dec);
        dec_eff       = dec_ext;
        err_d         = err_q;
        if (dec_ext > outstanding_q) begin
            err_d   = 1'b1;
            dec_eff = outstanding_q;
        end
        cnt_sum       = {1'b0, outstanding_q} + CW1'(inc) - {1'b0, dec_eff};
        outstanding_d = (cnt_sum > OUT_SAT) ? OUT_SAT[CW-1:0] : cnt_sum[CW-1:0];
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        base      = (PRIORITY_MODE == 0) ? 32'(rr_ptr_q) : 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = base + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_found && (((req >> cand) & NUM_REQ'(1)) != '0)) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        hold_cnt_d  = hold_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        hold_sum    = '0;
        release_req = 1'b0;
        go_idle     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d     = S_GRANTED;
                    grant_d     = NUM_REQ'(1) << win_idx;
                    grant_idx_d = win_idx;
                    hold_cnt_d  = '0;
                end
            end
            S_GRANTED: begin
                release_req = ~|(req & grant_q);
                if (HOLD_MAX != 0) begin
                    hold_sum   = {1'b0, hold_cnt_q} + HW1'(inc);
                    hold_cnt_d = (hold_sum > HOLD_LIM) ? HOLD_LIM[HW-1:0] : hold_sum[HW-1:0];
                    if (({1'b0, hold_cnt_q} >= HOLD_LIM) && (|(req & ~grant_q)))
                        release_req = 1'b1;
                end
                if (release_req) begin
                    if (outstanding_d == '0) go_idle = 1'b1;
                    else                     state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outstanding_d == '0) go_idle = 1'b1;
            end
            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_d     = S_IDLE;
            grant_d     = '0;
            grant_idx_d = '0;
            hold_cnt_d  = '0;
            if (PRIORITY_MODE == 0)
                rr_ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            hold_cnt_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            hold_cnt_q    <= hold_cnt_d;
            err_q         <= err_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = |grant_q;
    assign addr_block  = (state_q == S_DRAIN) || (outstanding_q >= OUT_LIM);
    assign idle        = (state_q == S_IDLE) && (outstanding_q == '0);
    assign err         = err_q;

endmodule

// File: tb/tb_holy_axi_arbiter.sv
// Bench for holy_axi_arbiter: three configurations on shared AXI stimulus, a directed vector
// table, hand-written corner sequences and a randomized run against a behavioural model.
module tb_holy_axi_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] req_a, req_c;
    logic [2:0] req_b;
    logic arvalid, arready, awvalid, awready, rvalid, rready, rlast, bvalid, bready;

    logic [1:0] g_a, g_c;
    logic [2:0] g_b;
    logic       gi_a, gi_c;
    logic [1:0] gi_b;
    logic       gv_a, gv_b, gv_c, ab_a, ab_b, ab_c, idle_a, idle_b, idle_c, err_a, err_b, err_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    holy_axi_arbiter #(.NUM_REQ(2), .PRIORITY_MODE(0), .MAX_OUTSTANDING(4), .HOLD_MAX(0)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .grant(g_a), .grant_idx(gi_a), .grant_valid(gv_a),
        .addr_block(ab_a), .arvalid(arvalid), .arready(arready), .awvalid(awvalid),
        .awready(awready), .rvalid(rvalid), .rready(rready), .rlast(rlast), .bvalid(bvalid),
        .bready(bready), .idle(idle_a), .err(err_a));

    holy_axi_arbiter #(.NUM_REQ(3), .PRIORITY_MODE(0), .MAX_OUTSTANDING(2), .HOLD_MAX(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .grant(g_b), .grant_idx(gi_b), .grant_valid(gv_b),
        .addr_block(ab_b), .arvalid(arvalid), .arready(arready), .awvalid(awvalid),
        .awready(awready), .rvalid(rvalid), .rready(rready), .rlast(rlast), .bvalid(bvalid),
        .bready(bready), .idle(idle_b), .err(err_b));

    holy_axi_arbiter #(.NUM_REQ(2), .PRIORITY_MODE(1), .MAX_OUTSTANDING(4), .HOLD_MAX(0)) dut_c (
        .clk(clk), .rst(rst), .req(req_c), .grant(g_c), .grant_idx(gi_c), .grant_valid(gv_c),
        .addr_block(ab_c), .arvalid(arvalid), .arready(arready), .awvalid(awvalid),
        .awready(awready), .rvalid(rvalid), .rready(rready), .rlast(rlast), .bvalid(bvalid),
        .bready(bready), .idle(idle_c), .err(err_c));

    // Reference model: owner index (-1 = nobody), drain flag and plain integer counters.
    int cfg_n[3]   = '{2, 3, 2};
    int cfg_pm[3]  = '{0, 0, 1};
    int cfg_mx[3]  = '{4, 2, 4};
    int cfg_h[3]   = '{0, 1, 0};
    int cfg_cap[3] = '{15, 7, 15};

    int m_owner[3], m_cnt[3], m_hold[3], m_ptr[3];
    bit m_drain[3], m_err[3];

    function automatic int req_of(int k);
        case (k)
            0:       return int'(req_a);
            1:       return int'(req_b);
            default: return int'(req_c);
        endcase
    endfunction

    function automatic int pick(int k, int r);
        for (int i = 0; i < cfg_n[k]; i++) begin
            int c;
            c = (cfg_pm[k] != 0) ? i : (m_ptr[k] + i) % cfg_n[k];
            if (((r >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    task automatic model_release(int k);
        if (cfg_pm[k] == 0) m_ptr[k] = (m_owner[k] + 1) % cfg_n[k];
        m_owner[k] = -1;
        m_drain[k] = 1'b0;
        m_hold[k]  = 0;
    endtask

    task automatic model_step();
        int ar, aw, rl, bb, r, inc, dec, d, nc, others;
        bit rel;
        ar = (arvalid && arready) ? 1 : 0;
        aw = (awvalid && awready) ? 1 : 0;
        rl = (rvalid && rready && rlast) ? 1 : 0;
        bb = (bvalid && bready) ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_owner[k] = -1; m_drain[k] = 1'b0; m_cnt[k] = 0;
                m_hold[k] = 0;   m_ptr[k] = 0;      m_err[k] = 1'b0;
            end else begin
                r   = req_of(k);
                inc = (m_owner[k] >= 0) ? ar + aw : 0;
                dec = rl + bb;
                if (dec > m_cnt[k]) begin
                    m_err[k] = 1'b1;
                    d = m_cnt[k];
                end else d = dec;
                nc = m_cnt[k] + inc - d;
                if (nc > cfg_cap[k]) nc = cfg_cap[k];
                if (m_owner[k] < 0) begin
                    if (r != 0) begin
                        m_owner[k] = pick(k, r);
                        m_drain[k] = 1'b0;
                        m_hold[k]  = 0;
                    end
                end else if (!m_drain[k]) begin
                    others = r & ~(1 << m_owner[k]);
                    rel = (((r >> m_owner[k]) & 1) == 0) ||
                          (cfg_h[k] != 0 && m_hold[k] >= cfg_h[k] && others != 0);
                    if (cfg_h[k] != 0)
                        m_hold[k] = (m_hold[k] + inc > cfg_h[k]) ? cfg_h[k] : m_hold[k] + inc;
                    if (rel) begin
                        if (nc == 0) model_release(k);
                        else         m_drain[k] = 1'b1;
                    end
                end else if (nc == 0) model_release(k);
                m_cnt[k] = nc;
            end
        end
    endtask

    function automatic logic [8:0] model_vec(int k);
        logic [2:0] g3;
        logic [1:0] i2;
        logic gv, ab, id;
        g3 = (m_owner[k] >= 0) ? 3'(1 << m_owner[k]) : 3'b000;
        i2 = (m_owner[k] >= 0) ? 2'(m_owner[k]) : 2'b00;
        gv = (m_owner[k] >= 0);
        ab = m_drain[k] || (m_cnt[k] >= cfg_mx[k]);
        id = (m_owner[k] < 0) && (m_cnt[k] == 0);
        return {g3, i2, gv, ab, id, m_err[k]};
    endfunction

    task automatic check(string name, logic [8:0] act, logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_dut_a", {1'b0, g_a, 1'b0, gi_a, gv_a, ab_a, idle_a, err_a}, model_vec(0));
        check("model_dut_b", {g_b, gi_b, gv_b, ab_b, idle_b, err_b}, model_vec(1));
        check("model_dut_c", {1'b0, g_c, 1'b0, gi_c, gv_c, ab_c, idle_c, err_c}, model_vec(2));
    endtask

    task automatic set_axi(bit ar, bit aw, bit rl, bit b);
        arvalid = ar; arready = ar; awvalid = aw; awready = aw;
        rvalid = rl; rready = rl; rlast = rl; bvalid = b; bready = b;
    endtask

    task automatic rand_axi();
        arvalid = ($urandom_range(0, 2) == 0); arready = ($urandom_range(0, 1) == 0);
        awvalid = ($urandom_range(0, 2) == 0); awready = ($urandom_range(0, 1) == 0);
        rvalid  = ($urandom_range(0, 1) == 0); rready  = ($urandom_range(0, 1) == 0);
        rlast   = ($urandom_range(0, 3) != 0);
        bvalid  = ($urandom_range(0, 1) == 0); bready  = ($urandom_range(0, 1) == 0);
    endtask

    typedef struct {
        bit rst; logic [1:0] req; bit ar, aw, rl, b;
        logic [1:0] g; bit ab, idle, err;
    } vec_t;

    vec_t tbl[22];
    logic [2:0] rot_exp[4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    initial begin
        //           rst req    ar aw rl b   grant  ab idle err
        tbl[0]  = '{1, 2'b11, 0, 0, 0, 0, 2'b00, 0, 1, 0};
        tbl[1]  = '{0, 2'b11, 0, 0, 0, 0, 2'b01, 0, 0, 0};
        tbl[2]  = '{0, 2'b11, 1, 0, 0, 0, 2'b01, 0, 0, 0};
        tbl[3]  = '{0, 2'b11, 1, 0, 0, 0, 2'b01, 0, 0, 0};
        tbl[4]  = '{0, 2'b11, 1, 0, 0, 0, 2'b01, 0, 0, 0};
        tbl[5]  = '{0, 2'b10, 0, 0, 0, 0, 2'b01, 1, 0, 0};
        tbl[6]  = '{0, 2'b10, 0, 0, 1, 0, 2'b01, 1, 0, 0};
        tbl[7]  = '{0, 2'b10, 0, 0, 1, 0, 2'b01, 1, 0, 0};
        tbl[8]  = '{0, 2'b10, 0, 0, 1, 0, 2'b00, 0, 1, 0};
        tbl[9]  = '{0, 2'b10, 0, 0, 0, 0, 2'b10, 0, 0, 0};
        tbl[10] = '{0, 2'b10, 1, 0, 0, 0, 2'b10, 0, 0, 0};
        tbl[11] = '{0, 2'b10, 1, 0, 1, 0, 2'b10, 0, 0, 0};
        tbl[12] = '{0, 2'b10, 0, 0, 1, 0, 2'b10, 0, 0, 0};
        tbl[13] = '{0, 2'b10, 0, 0, 0, 1, 2'b10, 0, 0, 1};
        tbl[14] = '{0, 2'b10, 1, 1, 0, 0, 2'b10, 0, 0, 1};
        tbl[15] = '{0, 2'b10, 0, 1, 0, 0, 2'b10, 0, 0, 1};
        tbl[16] = '{0, 2'b10, 1, 0, 0, 0, 2'b10, 1, 0, 1};
        tbl[17] = '{0, 2'b10, 0, 0, 0, 1, 2'b10, 0, 0, 1};
        tbl[18] = '{0, 2'b00, 0, 0, 0, 0, 2'b10, 1, 0, 1};
        tbl[19] = '{1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 0};
        tbl[20] = '{0, 2'b01, 0, 0, 0, 0, 2'b01, 0, 0, 0};
        tbl[21] = '{0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 0};

        rst = 1'b1; req_a = '0; req_b = '0; req_c = '0;
        set_axi(0, 0, 0, 0);

        for (int i = 0; i < 22; i++) begin
            rst = tbl[i].rst; req_a = tbl[i].req; req_b = '0; req_c = '0;
            set_axi(tbl[i].ar, tbl[i].aw, tbl[i].rl, tbl[i].b);
            tick();
            check($sformatf("table_row%0d", i),
                  {1'b0, g_a, 1'b0, gi_a, gv_a, ab_a, idle_a, err_a},
                  {1'b0, tbl[i].g, 1'b0, (tbl[i].g == 2'b10), (tbl[i].g != 2'b00),
                   tbl[i].ab, tbl[i].idle, tbl[i].err});
        end

        // Cap of two: two AR handshakes block, one R last unblocks on the following cycle.
        req_a = '0; req_c = '0; req_b = '0; set_axi(0, 0, 0, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        req_b = 3'b001; tick();
        set_axi(1, 0, 0, 0); tick(); tick();
        check("maxout_block", {8'b0, ab_b}, 9'd1);
        set_axi(0, 0, 1, 0); tick();
        check("maxout_unblock", {8'b0, ab_b}, 9'd0);
        tick();
        set_axi(0, 0, 0, 0); req_b = '0; tick();

        // Forced rotation after one address handshake per grant.
        rst = 1'b1; tick(); rst = 1'b0;
        req_b = 3'b111;
        for (int n = 0; n < 4; n++) begin
            int waited = 0;
            while (g_b == 3'b000 && waited < 10) begin
                tick();
                waited++;
            end
            check($sformatf("rotate_grant%0d", n), {6'b0, g_b}, {6'b0, rot_exp[n]});
            set_axi(1, 0, 0, 0); tick();
            set_axi(0, 0, 1, 0); tick();
            set_axi(0, 0, 0, 0);
        end
        req_b = '0;

        // Fixed priority with both requesting and no hold limit keeps requester 0 forever.
        rst = 1'b1; tick(); rst = 1'b0;
        req_c = 2'b11; tick();
        for (int n = 0; n < 40; n++) begin
            rand_axi();
            tick();
            check("fixed_prio_hold", {7'b0, g_c}, 9'b000000001);
        end
        req_c = '0; set_axi(0, 0, 0, 0);

        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) req_a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) req_b = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) req_c = 2'($urandom_range(0, 3));
            rand_axi();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
